cve2_rvfi_trace_buffer: RTL and testbench
=========================================

Name: cve2_rvfi_trace_buffer

Overview:
- Parametrised capture buffer for retired-instruction records from the cve2 RVFI port. It is the next generation of the tracing top-level.
- Records are stored on-chip instead of printed by a simulation-only tracer, so traces survive in FPGA/emulation builds.
- Two modes: stream (FIFO, drop-on-full with a drop counter) and ring (overwrite oldest, freeze a configurable number of records after a trigger).
- Sits beside cve2_top, fed by its rvfi_* outputs. It is drained through a valid/ready record port by a debug or DMA agent.

Parameters:
- Depth, 16, number of record entries; power of two, >= 2.
- PostTrig, 8, records captured after trigger in ring mode before freezing; 0..Depth-1.
- DropCntWidth, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  capture enable.
- mode_i  in  1  0 = stream, 1 = ring; latched into mode_q only while the buffer is empty.
- flush_i  in  1  synchronous clear of entries, freeze, trigger state and drop counter.
- trig_i  in  1  trigger pulse; ring mode only.
- rvfi_valid_i  in  1  retire strobe.
- rvfi_pc_rdata_i  in  32  PC of the retired instruction.
- rvfi_insn_i  in  32  instruction word.
- rvfi_rd_addr_i  in  5  destination register.
- rvfi_rd_wdata_i  in  32  destination write data.
- rvfi_trap_i  in  1  trap flag.
- rvfi_intr_i  in  1  interrupt flag.
- rec_valid_o  out  1  oldest record available.
- rec_ready_i  in  1  consumer accepts the record.
- rec_o  out  trace_rec_t  oldest record (packed struct).
- count_o  out  $clog2(Depth)+1  current occupancy.
- drop_cnt_o  out  DropCntWidth  records lost in stream mode.
- frozen_o  out  1  ring capture frozen after trigger.

Behaviour:
- Reset: all pointers, count_o, drop_cnt_o, frozen_o, rec_valid_o and the trigger state go to 0; mode_q goes to 0 (stream). Entry storage is not reset, and rec_o is don't-care while rec_valid_o=0.
- Push condition: push = enable_i & rvfi_valid_i & ~frozen_o & ~flush_i.
- Pop condition: pop = rec_valid_o & rec_ready_i.
- Output timing: first-word fall-through. rec_valid_o = (count != 0) and rec_o = mem[rd_ptr], both from registers with no combinational path from the rvfi inputs. A record pushed in cycle N is visible in cycle N+1.
- Pointers: wr_ptr and rd_ptr are $clog2(Depth) bits and wrap naturally. Count is updated +1, -1 or 0.
- Stream mode, not full: push writes mem[wr_ptr] and increments wr_ptr.
- Stream mode, full without a same-cycle pop: the record is dropped and drop_cnt increments, saturating at 2^DropCntWidth-1.
- Stream mode, full with a same-cycle pop: push is accepted, count stays at Depth, no drop.
- Ring mode, full without pop: push overwrites the oldest entry; wr_ptr and rd_ptr both advance and count stays at Depth. drop_cnt is unchanged.
- Ring mode, full with pop: same as stream mode (no overwrite).
- Trigger FSM (ring mode only), states IDLE -> ARMED -> FROZEN:
  - IDLE -> ARMED on trig_i; post_cnt is loaded with PostTrig.
  - ARMED decrements post_cnt on each accepted push. On the cycle post_cnt is 0 it moves to FROZEN; if PostTrig=0 it freezes on the trigger cycle itself.
  - FROZEN sets frozen_o=1 and blocks pushes. Pops still drain the buffer, and it stays FROZEN when empty.
  - trig_i while ARMED or FROZEN is ignored. trig_i in stream mode is ignored.
  - A trigger coincident with a push: that push is captured and is not counted toward PostTrig.
- flush_i has highest priority: it zeroes pointers, count, drop_cnt and frozen, and returns the FSM to IDLE. A pop in the same cycle is discarded.
- Mode latching: mode_q <= mode_i on any cycle where count == 0 and no push occurs, or on flush. A mode change while occupied is deferred.
- Reset asserted mid-operation aborts everything to reset state asynchronously.

Optional Feature:
- CVE2_TRACE_MEM_EN defined: trace_rec_t adds mem_addr[31:0], mem_wmask[3:0] and mem_wdata[31:0]. Matching inputs rvfi_mem_addr_i, rvfi_mem_wmask_i and rvfi_mem_wdata_i are added, and entries are stored in full.
- Not defined: these ports and fields are absent and entry width is 103 bits.

Decomposition:
- cve2_trace_pkg: trace_rec_t (conditional fields), trace_mode_e {TraceStream, TraceRing}, trig_state_e {TrigIdle, TrigArmed, TrigFrozen}.
- One sub-module, cve2_trace_ring_mem: Depth x $bits(trace_rec_t) register array with one write port and an asynchronous read port. Pointer, count, FSM and drop logic stay in the top module.

Test Plan:
- Stream mode, Depth=16, 20 back-to-back retires (pc=0x80+4i), rec_ready_i=0 -> count_o=16, drop_cnt_o=4; draining yields pc 0x80..0xBC in order.
- Stream mode, full, push and pop in the same cycle -> count_o stays 16, drop_cnt_o unchanged, the new record appears last.
- Ring mode, 20 retires, no trigger -> count_o=16 and the drain starts at pc 0x90.
- Ring mode, PostTrig=8, trigger at retire 10, then 20 more retires -> frozen_o=1 after the 8th post-trigger push; count_o=16; last drained pc = 0x80+4*18.
- drop_cnt saturation: DropCntWidth=2, 10 drops -> drop_cnt_o=3. Then flush_i -> count_o=0, drop_cnt_o=0, frozen_o=0.
- Async reset mid-drain with count_o=5 -> all outputs 0 in the same cycle; the next push is visible one cycle later.

Source files
------------

// File: rtl/cve2_trace_pkg.sv
// cve2_trace_pkg
// Shared types for the RVFI trace buffer.
//   trace_rec_t  : one retired-instruction record as stored in the buffer.
//                  103 bits by default; with CVE2_TRACE_MEM_EN defined it also
//                  carries the data-memory address, write mask and write data.
//   trace_mode_e : capture mode (stream FIFO or overwrite-oldest ring).
//   trig_state_e : ring-mode trigger FSM states.
// Optional feature macro: CVE2_TRACE_MEM_EN.
package cve2_trace_pkg;

  typedef struct packed {
`ifdef CVE2_TRACE_MEM_EN
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
`endif
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  typedef enum logic {
    TraceStream = 1'b0,
    TraceRing   = 1'b1
  } trace_mode_e;

  typedef enum logic [1:0] {
    TrigIdle   = 2'd0,
    TrigArmed  = 2'd1,
    TrigFrozen = 2'd2
  } trig_state_e;

endpackage

// File: rtl/cve2_rvfi_trace_buffer_if.sv
// cve2_rvfi_trace_buffer_if
// Bundles the RVFI retire inputs and the drain-side record port.
//   rvfi_*      : retired-instruction fields from cve2_top (producer side).
//   rec_valid_o : a record is available at rec_o.
//   rec_ready_i : consumer accepts rec_o.
//   rec_o       : oldest stored record.
// Handshake: a record transfers on every clock edge where rec_valid_o and
// rec_ready_i are both 1. rec_valid_o never depends on rec_ready_i, and rec_o
// is stable while rec_valid_o=1 and no transfer happens (unless a ring-mode
// overwrite replaces the oldest entry). rvfi_valid_i is a strobe without
// backpressure: a retire the buffer cannot store is dropped or overwrites.
// Optional feature macro: CVE2_TRACE_MEM_EN adds rvfi_mem_* signals.
interface cve2_rvfi_trace_buffer_if;
  import cve2_trace_pkg::*;

  logic        rvfi_valid_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic        rvfi_trap_i;
  logic        rvfi_intr_i;
`ifdef CVE2_TRACE_MEM_EN
  logic [31:0] rvfi_mem_addr_i;
  logic [3:0]  rvfi_mem_wmask_i;
  logic [31:0] rvfi_mem_wdata_i;
`endif
  logic        rec_valid_o;
  logic        rec_ready_i;
  trace_rec_t  rec_o;

  // Buffer side.
  modport slave (
    input  rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i,
           rvfi_rd_wdata_i, rvfi_trap_i, rvfi_intr_i,
`ifdef CVE2_TRACE_MEM_EN
           rvfi_mem_addr_i, rvfi_mem_wmask_i, rvfi_mem_wdata_i,
`endif
           rec_ready_i,
    output rec_valid_o, rec_o
  );

  // Core + drain agent side.
  modport master (
    output rvfi_valid_i, rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i,
           rvfi_rd_wdata_i, rvfi_trap_i, rvfi_intr_i,
`ifdef CVE2_TRACE_MEM_EN
           rvfi_mem_addr_i, rvfi_mem_wmask_i, rvfi_mem_wdata_i,
`endif
           rec_ready_i,
    input  rec_valid_o, rec_o
  );

endinterface

// File: rtl/cve2_trace_ring_mem.sv
// cve2_trace_ring_mem
// Depth x $bits(trace_rec_t) register array, one write port, one
// asynchronous read port. Storage is intentionally not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : record to write
//   i_raddr : read index
//   o_rdata : record at i_raddr (combinational read)
// Optional feature macro: CVE2_TRACE_MEM_EN (widens trace_rec_t).
module cve2_trace_ring_mem
  import cve2_trace_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_waddr,
  input  trace_rec_t               i_wdata,
  input  logic [$clog2(Depth)-1:0] i_raddr,
  output trace_rec_t               o_rdata
);

  trace_rec_t r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// cve2_rvfi_trace_buffer
// On-chip capture buffer for cve2 RVFI retire records, drained through a
// first-word-fall-through valid/ready port.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   enable_i      : capture enable
//   mode_i        : 0 stream (drop on full), 1 ring (overwrite oldest);
//                   taken into mode_q only while empty or on flush
//   flush_i       : synchronous clear of entries, drop count, trigger state
//   trig_i        : ring-mode trigger pulse
//   rvfi_bus      : RVFI inputs + record port (cve2_rvfi_trace_buffer_if.slave)
//   count_o       : occupancy
//   drop_cnt_o    : saturating count of records lost in stream mode
//   frozen_o      : ring capture frozen after trigger
//   trig_state_o  : trigger FSM state (debug visibility)
// Optional feature macro: CVE2_TRACE_MEM_EN stores rvfi_mem_* fields as well.
module cve2_rvfi_trace_buffer
  import cve2_trace_pkg::*;
#(
  parameter int Depth        = 16,
  parameter int PostTrig     = 8,
  parameter int DropCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     mode_i,
  input  logic                     flush_i,
  input  logic                     trig_i,
  cve2_rvfi_trace_buffer_if.slave  rvfi_bus,
  output logic [$clog2(Depth):0]   count_o,
  output logic [DropCntWidth-1:0]  drop_cnt_o,
  output logic                     frozen_o,
  output trig_state_e              trig_state_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(Depth);
  localparam logic [AW-1:0] PostInit = AW'(PostTrig);

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [DropCntWidth-1:0] r_drop_cnt;
  trace_mode_e             r_mode;
  trig_state_e             r_trig_state;
  trig_state_e             w_trig_next;
  logic [AW-1:0]           r_post_cnt;
  logic [AW-1:0]           w_post_cnt_next;

  logic       w_full;
  logic       w_rec_valid;
  logic       w_frozen;
  logic       w_ring;
  logic       w_push;
  logic       w_pop;
  logic       w_accept;
  logic       w_drop;
  logic       w_overwrite;
  logic       w_rd_adv;
  trace_rec_t w_wr_rec;
  trace_rec_t w_rd_rec;

  assign w_full      = (r_count == FullCnt);
  assign w_rec_valid = (r_count != '0);
  assign w_frozen    = (r_trig_state == TrigFrozen);
  assign w_ring      = (r_mode == TraceRing);

  assign w_push = enable_i & rvfi_bus.rvfi_valid_i & ~w_frozen & ~flush_i;
  assign w_pop  = w_rec_valid & rvfi_bus.rec_ready_i;

  // A full buffer takes the push if a slot frees this cycle or in ring mode;
  // otherwise stream mode loses it.
  assign w_accept    = w_push & (~w_full | w_pop | w_ring);
  assign w_drop      = w_push & w_full & ~w_pop & ~w_ring;
  assign w_overwrite = w_push & w_full & ~w_pop & w_ring;
  // Overwrite discards the oldest entry, so the read side moves with it.
  assign w_rd_adv    = w_pop | w_overwrite;

  always_comb begin
    w_wr_rec          = '0;
    w_wr_rec.pc       = rvfi_bus.rvfi_pc_rdata_i;
    w_wr_rec.insn     = rvfi_bus.rvfi_insn_i;
    w_wr_rec.rd_addr  = rvfi_bus.rvfi_rd_addr_i;
    w_wr_rec.rd_wdata = rvfi_bus.rvfi_rd_wdata_i;
    w_wr_rec.trap     = rvfi_bus.rvfi_trap_i;
    w_wr_rec.intr     = rvfi_bus.rvfi_intr_i;
`ifdef CVE2_TRACE_MEM_EN
    w_wr_rec.mem_addr  = rvfi_bus.rvfi_mem_addr_i;
    w_wr_rec.mem_wmask = rvfi_bus.rvfi_mem_wmask_i;
    w_wr_rec.mem_wdata = rvfi_bus.rvfi_mem_wdata_i;
`endif
  end

  cve2_trace_ring_mem #(
    .Depth (Depth)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_rec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_rec)
  );

  // Pointers, occupancy, drop counter and mode latch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_mode     <= TraceStream;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_mode     <= trace_mode_e'(mode_i);
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept && !w_rd_adv)     r_count <= r_count + CW'(1);
      else if (w_pop && !w_accept)   r_count <= r_count - CW'(1);
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
      // Mode changes only take effect on an empty, idle buffer.
      if ((r_count == '0) && !w_push) r_mode <= trace_mode_e'(mode_i);
    end
  end

  // Trigger FSM: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trig_state <= TrigIdle;
      r_post_cnt   <= '0;
    end else begin
      r_trig_state <= w_trig_next;
      r_post_cnt   <= w_post_cnt_next;
    end
  end

  // Trigger FSM: next state. The push coincident with the trigger is taken
  // while still idle, so it does not count toward the post-trigger budget.
  // Freezing happens on the edge that accepts the last post-trigger push.
  always_comb begin
    w_trig_next     = r_trig_state;
    w_post_cnt_next = r_post_cnt;
    case (r_trig_state)
      TrigIdle: begin
        if (trig_i && w_ring) begin
          if (PostTrig == 0) begin
            w_trig_next = TrigFrozen;
          end else begin
            w_trig_next     = TrigArmed;
            w_post_cnt_next = PostInit;
          end
        end
      end
      TrigArmed: begin
        if (w_accept) begin
          w_post_cnt_next = r_post_cnt - AW'(1);
          if (r_post_cnt == AW'(1)) w_trig_next = TrigFrozen;
        end
      end
      TrigFrozen: w_trig_next = TrigFrozen;
      default:    w_trig_next = TrigIdle;
    endcase
    if (flush_i) w_trig_next = TrigIdle;
  end

  assign rvfi_bus.rec_valid_o = w_rec_valid;
  assign rvfi_bus.rec_o       = w_rd_rec;
  assign count_o              = r_count;
  assign drop_cnt_o           = r_drop_cnt;
  assign frozen_o             = w_frozen;
  assign trig_state_o         = r_trig_state;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// tb_cve2_rvfi_trace_buffer
// Two buffers (drop counter 16 bits and 2 bits) fed the same stimulus and
// checked every cycle against a queue-based model of the buffer, plus
// directed scenarios with hand-computed expectations.
module tb_cve2_rvfi_trace_buffer;
  import cve2_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int POST  = 8;
  localparam int RW    = $bits(trace_rec_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic enable, mode, flush, trig, valid, ready;
  trace_rec_t cur_rec;

  cve2_rvfi_trace_buffer_if bus1 ();
  cve2_rvfi_trace_buffer_if bus2 ();

  assign bus1.rvfi_valid_i    = valid;
  assign bus1.rvfi_pc_rdata_i = cur_rec.pc;
  assign bus1.rvfi_insn_i     = cur_rec.insn;
  assign bus1.rvfi_rd_addr_i  = cur_rec.rd_addr;
  assign bus1.rvfi_rd_wdata_i = cur_rec.rd_wdata;
  assign bus1.rvfi_trap_i     = cur_rec.trap;
  assign bus1.rvfi_intr_i     = cur_rec.intr;
  assign bus1.rec_ready_i     = ready;
  assign bus2.rvfi_valid_i    = valid;
  assign bus2.rvfi_pc_rdata_i = cur_rec.pc;
  assign bus2.rvfi_insn_i     = cur_rec.insn;
  assign bus2.rvfi_rd_addr_i  = cur_rec.rd_addr;
  assign bus2.rvfi_rd_wdata_i = cur_rec.rd_wdata;
  assign bus2.rvfi_trap_i     = cur_rec.trap;
  assign bus2.rvfi_intr_i     = cur_rec.intr;
  assign bus2.rec_ready_i     = ready;
`ifdef CVE2_TRACE_MEM_EN
  assign bus1.rvfi_mem_addr_i  = cur_rec.mem_addr;
  assign bus1.rvfi_mem_wmask_i = cur_rec.mem_wmask;
  assign bus1.rvfi_mem_wdata_i = cur_rec.mem_wdata;
  assign bus2.rvfi_mem_addr_i  = cur_rec.mem_addr;
  assign bus2.rvfi_mem_wmask_i = cur_rec.mem_wmask;
  assign bus2.rvfi_mem_wdata_i = cur_rec.mem_wdata;
`endif

  logic [4:0]  count1, count2;
  logic [15:0] drop1;
  logic [1:0]  drop2;
  logic        frozen1, frozen2;
  trig_state_e st1, st2;

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .PostTrig(POST), .DropCntWidth(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .flush_i(flush),
    .trig_i(trig), .rvfi_bus(bus1), .count_o(count1), .drop_cnt_o(drop1),
    .frozen_o(frozen1), .trig_state_o(st1)
  );

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .PostTrig(POST), .DropCntWidth(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode), .flush_i(flush),
    .trig_i(trig), .rvfi_bus(bus2), .count_o(count2), .drop_cnt_o(drop2),
    .frozen_o(frozen2), .trig_state_o(st2)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [RW-1:0] exp_q[$];
  int m_drop;
  bit m_mode;
  bit m_armed;
  bit m_frozen;
  int m_post_left;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_drop = 0; m_mode = 1'b0; m_armed = 1'b0; m_frozen = 1'b0; m_post_left = 0;
  endfunction

  // One clock edge of the buffer, from the currently driven inputs.
  function automatic void model_step();
    bit was_empty, pop, push, taken;
    if (flush) begin
      exp_q.delete();
      m_drop = 0; m_armed = 1'b0; m_frozen = 1'b0; m_mode = mode;
      return;
    end
    was_empty = (exp_q.size() == 0);
    pop   = !was_empty && ready;
    push  = enable && valid && !m_frozen;
    taken = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(cur_rec); taken = 1'b1;
      end else if (m_mode) begin
        void'(exp_q.pop_front()); exp_q.push_back(cur_rec); taken = 1'b1;
      end else begin
        m_drop++;
      end
    end
    if (m_armed) begin
      if (taken) begin
        m_post_left--;
        if (m_post_left == 0) begin m_armed = 1'b0; m_frozen = 1'b1; end
      end
    end else if (!m_frozen && trig && m_mode) begin
      if (POST == 0) m_frozen = 1'b1;
      else begin m_armed = 1'b1; m_post_left = POST; end
    end
    if (was_empty && !push) m_mode = mode;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count1", count1, exp_q.size());
      chk("count2", count2, exp_q.size());
      chk("rec_valid1", bus1.rec_valid_o, exp_q.size() != 0);
      chk("rec_valid2", bus2.rec_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rec1", bus1.rec_o, exp_q[0]);
        chk("rec2", bus2.rec_o, exp_q[0]);
      end
      chk("drop1", drop1, sat(m_drop, 65535));
      chk("drop2", drop2, sat(m_drop, 3));
      chk("frozen1", frozen1, m_frozen);
      chk("frozen2", frozen2, m_frozen);
      chk("trig_state1", st1, m_frozen ? TrigFrozen : (m_armed ? TrigArmed : TrigIdle));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic trace_rec_t mk_rec(input logic [31:0] pc);
    trace_rec_t r;
    r          = '0;
    r.pc       = pc;
    r.insn     = $urandom;
    r.rd_addr  = 5'($urandom_range(0, 31));
    r.rd_wdata = $urandom;
    r.trap     = 1'($urandom_range(0, 1));
    r.intr     = 1'($urandom_range(0, 1));
`ifdef CVE2_TRACE_MEM_EN
    r.mem_addr  = $urandom;
    r.mem_wmask = 4'($urandom_range(0, 15));
    r.mem_wdata = $urandom;
`endif
    return r;
  endfunction

  task automatic cyc(input bit en, input bit v, input bit rdy, input bit tr,
                     input bit fl, input bit md, input trace_rec_t rec);
    enable = en; valid = v; ready = rdy; trig = tr; flush = fl; mode = md; cur_rec = rec;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit md;
    int rdy_pct;
    enable = 0; mode = 0; flush = 0; trig = 0; valid = 0; ready = 0; cur_rec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    chk("rst_count", count1, 0);
    chk("rst_valid", bus1.rec_valid_o, 0);
    chk("rst_drop", drop1, 0);
    chk("rst_frozen", frozen1, 0);

    // Stream: 20 retires without draining, then 10 more drops.
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0, mk_rec(32'h80 + 4 * i));
    chk("s_full_count", count1, 16);
    chk("s_drop4", drop1, 4);
    chk("s_drop4_sat2", drop2, 3);
    for (int i = 20; i < 30; i++) cyc(1, 1, 0, 0, 0, 0, mk_rec(32'h80 + 4 * i));
    chk("s_drop14", drop1, 14);
    chk("s_drop_sat2", drop2, 3);
    for (int k = 0; k < 16; k++) begin
      chk("s_drain_pc", bus1.rec_o.pc, 32'h80 + 4 * k);
      cyc(0, 0, 1, 0, 0, 0, mk_rec(0));
    end
    chk("s_empty", count1, 0);

    // Stream full with push and pop in the same cycle.
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0, 0, mk_rec(32'h400 + 4 * i));
    cyc(1, 1, 1, 0, 0, 0, mk_rec(32'h500));
    chk("sp_count", count1, 16);
    chk("sp_drop", drop1, 14);
    for (int k = 0; k < 16; k++) begin
      chk("sp_drain_pc", bus1.rec_o.pc, (k == 15) ? 32'h500 : 32'h404 + 4 * k);
      cyc(0, 0, 1, 0, 0, 0, mk_rec(0));
    end

    // Flush into ring mode; flush clears the drop counter.
    cyc(0, 0, 0, 0, 1, 1, mk_rec(0));
    chk("fl_count", count1, 0);
    chk("fl_drop", drop1, 0);
    chk("fl_frozen", frozen1, 0);

    // Ring: 20 retires, no trigger.
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 1, mk_rec(32'h80 + 4 * i));
    chk("r_count", count1, 16);
    chk("r_first_pc", bus1.rec_o.pc, 32'h90);
    chk("r_drop", drop1, 0);
    for (int k = 0; k < 16; k++) begin
      chk("r_drain_pc", bus1.rec_o.pc, 32'h90 + 4 * k);
      cyc(0, 0, 1, 0, 0, 1, mk_rec(0));
    end

    // Ring with trigger at retire 10, then 20 more retires.
    cyc(0, 0, 0, 0, 1, 1, mk_rec(0));
    for (int i = 0; i < 31; i++) begin
      cyc(1, 1, 0, i == 10, 0, 1, mk_rec(32'h80 + 4 * i));
      if (i == 17) chk("t_not_frozen_yet", frozen1, 0);
      if (i == 18) chk("t_frozen_after_8", frozen1, 1);
    end
    chk("t_count", count1, 16);
    for (int k = 0; k < 16; k++) begin
      chk("t_drain_pc", bus1.rec_o.pc, 32'h8c + 4 * k);
      cyc(0, 0, 1, 0, 0, 1, mk_rec(0));
    end
    chk("t_frozen_empty", frozen1, 1);
    cyc(1, 1, 0, 0, 0, 1, mk_rec(32'h999));
    chk("t_frozen_blocks", count1, 0);
    cyc(0, 0, 0, 0, 1, 0, mk_rec(0));
    chk("t_flush_unfreeze", frozen1, 0);

    // Randomized traffic with varying drain pressure.
    md = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 85 : 50;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 99) < 5) md = ~md;
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) == 0, md, mk_rec($urandom));
      end
    end

    // Asynchronous reset while draining with five records held.
    cyc(0, 0, 0, 0, 1, 0, mk_rec(0));
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, mk_rec(32'h200 + 4 * i));
    chk("ar_count5", count1, 5);
    valid = 0; ready = 1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar_count0", count1, 0);
    chk("ar_valid0", bus1.rec_valid_o, 0);
    chk("ar_drop0", drop1, 0);
    chk("ar_frozen0", frozen1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1, 0, 0, 0, 0, mk_rec(32'h300));
    chk("ar_push_valid", bus1.rec_valid_o, 1);
    chk("ar_push_pc", bus1.rec_o.pc, 32'h300);
    cyc(0, 0, 0, 0, 0, 0, mk_rec(0));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
